// File: rtl/udp_checksum_check_pkg.sv
// Shared network definitions: UDP checksum location, FSM states and
// one's-complement arithmetic reused by the checksum blocks.
package udp_checksum_check_pkg;

  localparam int unsigned UDP_CSUM_OFFSET = 18;

  typedef enum logic [1:0] {
    S_RECV,
    S_FOLD,
    S_DECIDE,
    S_DROP
  } state_e;

  // 16-bit one's-complement add with the end-around carry folded back in
  function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'b0, s[16]};
  endfunction

endpackage

// File: rtl/udp_checksum_check_fifo.sv
// Packet buffer with separate write/commit/read pointers: readers only ever
// see committed words, and an uncommitted packet can be rewound away.
module axis_packet_fifo #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 1024
) (
  input  logic          clk,
  input  logic          sresetn,
  input  logic          wr_en_i,
  input  logic [DW:0]   wr_data_i,
  output logic          full_o,
  input  logic          commit_i,
  input  logic          rewind_i,
  output logic          m_tvalid_o,
  input  logic          m_tready_i,
  output logic [DW-1:0] m_tdata_o,
  output logic          m_tlast_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [DW:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] cmt_ptr_q, cmt_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          out_valid_q, out_valid_d;
  logic [DW:0]   out_word_q, out_word_d;
  logic          load;

  assign full_o = (wr_ptr_q + PW'(1)) == rd_ptr_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    cmt_ptr_d   = cmt_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;
    if (rewind_i) begin
      wr_ptr_d = cmt_ptr_q;
    end else if (wr_en_i) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (commit_i) begin
      cmt_ptr_d = wr_ptr_q;
    end
    // Output register refills whenever it is empty or being consumed
    load = (rd_ptr_q != cmt_ptr_q) && (!out_valid_q || m_tready_i);
    if (load) begin
      rd_ptr_d    = rd_ptr_q + PW'(1);
      out_valid_d = 1'b1;
      out_word_d  = mem[rd_ptr_q];
    end else if (m_tready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      wr_ptr_q    <= '0;
      cmt_ptr_q   <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      cmt_ptr_q   <= cmt_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
    end
  end

  assign m_tvalid_o = out_valid_q;
  assign m_tdata_o  = out_word_q[DW-1:0];
  assign m_tlast_o  = out_word_q[DW];

endmodule

// File: rtl/udp_checksum_check.sv
// Store-and-forward UDP checksum checker: buffers each packet, forwards it
// only if the one's-complement sum verifies, and reports one status pulse.
module udp_checksum_check
  import udp_checksum_check_pkg::*;
#(
  parameter int unsigned AXIS_BYTES = 2,
  parameter int unsigned DEPTH      = 1024
) (
  input  logic                    clk,
  input  logic                    sresetn,
  output logic                    axis_i_tready,
  input  logic                    axis_i_tvalid,
  input  logic                    axis_i_tlast,
  input  logic [AXIS_BYTES*8-1:0] axis_i_tdata,
  input  logic                    axis_o_tready,
  output logic                    axis_o_tvalid,
  output logic                    axis_o_tlast,
  output logic [AXIS_BYTES*8-1:0] axis_o_tdata,
  output logic                    pkt_good,
  output logic                    pkt_bad_csum,
  output logic                    pkt_overflow
);

  localparam int unsigned DW        = AXIS_BYTES * 8;
  localparam int unsigned NL        = AXIS_BYTES / 2;
  localparam int unsigned CSUM_WORD = UDP_CSUM_OFFSET / AXIS_BYTES;
  localparam int unsigned CSUM_LSB  = (AXIS_BYTES - 2 - (UDP_CSUM_OFFSET % AXIS_BYTES)) * 8;

  if (!(AXIS_BYTES == 2 || AXIS_BYTES == 4)) begin : g_bad_bytes
    $error("AXIS_BYTES must be 2 or 4");
  end
  if (DEPTH < 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two of at least 16");
  end

  state_e      state_q, state_d;
  logic [16:0] acc_q [NL];
  logic [16:0] acc_d [NL];
  logic [15:0] fsum_q, fsum_d;
  logic [15:0] csum_q, csum_d;
  logic        csum_vld_q, csum_vld_d;
  logic [3:0]  beat_q, beat_d;
  logic        fold_q, fold_d;
  logic        good_q, good_d, bad_q, bad_d, ovf_q, ovf_d;
  logic        wr_en, commit, rewind, full, clear, hs;

  assign hs = axis_i_tvalid && axis_i_tready;

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    fsum_d        = fsum_q;
    csum_d        = csum_q;
    csum_vld_d    = csum_vld_q;
    beat_d        = beat_q;
    fold_d        = fold_q;
    good_d        = 1'b0;
    bad_d         = 1'b0;
    ovf_d         = 1'b0;
    wr_en         = 1'b0;
    commit        = 1'b0;
    rewind        = 1'b0;
    clear         = 1'b0;
    axis_i_tready = 1'b0;
    case (state_q)
      S_RECV: begin
        axis_i_tready = 1'b1;
        if (hs) begin
          if (full) begin
            rewind = 1'b1;
            clear  = 1'b1;
            if (axis_i_tlast) ovf_d = 1'b1;
            else              state_d = S_DROP;
          end else begin
            wr_en = 1'b1;
            for (int unsigned l = 0; l < NL; l++) begin
              acc_d[l] = {1'b0, acc_q[l][15:0]} + {16'b0, acc_q[l][16]}
                       + {1'b0, axis_i_tdata[16*l +: 16]};
            end
            if (beat_q == 4'(CSUM_WORD)) begin
              csum_d     = axis_i_tdata[CSUM_LSB +: 16];
              csum_vld_d = 1'b1;
            end
            if (beat_q != '1) beat_d = beat_q + 4'd1;
            if (axis_i_tlast) begin
              state_d = S_FOLD;
              fold_d  = 1'b0;
            end
          end
        end
      end
      S_FOLD: begin
        // First cycle absorbs each lane's carry; a second cycle merges lanes
        if (!fold_q) begin
          for (int unsigned l = 0; l < NL; l++) begin
            acc_d[l] = {1'b0, ones_add(acc_q[l][15:0], {15'b0, acc_q[l][16]})};
          end
          fsum_d = ones_add(acc_q[0][15:0], {15'b0, acc_q[0][16]});
        end else begin
          fsum_d = ones_add(acc_q[0][15:0], acc_q[NL-1][15:0]);
        end
        if (NL == 1 || fold_q) state_d = S_DECIDE;
        else                   fold_d  = 1'b1;
      end
      S_DECIDE: begin
        if (fsum_q == 16'hFFFF || (csum_vld_q && csum_q == 16'h0000)) begin
          commit = 1'b1;
          good_d = 1'b1;
        end else begin
          rewind = 1'b1;
          bad_d  = 1'b1;
        end
        clear   = 1'b1;
        state_d = S_RECV;
      end
      S_DROP: begin
        axis_i_tready = 1'b1;
        if (hs && axis_i_tlast) begin
          ovf_d   = 1'b1;
          clear   = 1'b1;
          state_d = S_RECV;
        end
      end
      default: state_d = S_RECV;
    endcase
    if (clear) begin
      for (int unsigned l = 0; l < NL; l++) acc_d[l] = '0;
      csum_d     = '0;
      csum_vld_d = 1'b0;
      beat_d     = '0;
      fold_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      state_q    <= S_RECV;
      for (int unsigned l = 0; l < NL; l++) acc_q[l] <= '0;
      fsum_q     <= '0;
      csum_q     <= '0;
      csum_vld_q <= 1'b0;
      beat_q     <= '0;
      fold_q     <= 1'b0;
      good_q     <= 1'b0;
      bad_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      fsum_q     <= fsum_d;
      csum_q     <= csum_d;
      csum_vld_q <= csum_vld_d;
      beat_q     <= beat_d;
      fold_q     <= fold_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      ovf_q      <= ovf_d;
    end
  end

  assign pkt_good     = good_q;
  assign pkt_bad_csum = bad_q;
  assign pkt_overflow = ovf_q;

  axis_packet_fifo #(
    .DW   (DW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .sresetn   (sresetn),
    .wr_en_i   (wr_en),
    .wr_data_i ({axis_i_tlast, axis_i_tdata}),
    .full_o    (full),
    .commit_i  (commit),
    .rewind_i  (rewind),
    .m_tvalid_o(axis_o_tvalid),
    .m_tready_i(axis_o_tready),
    .m_tdata_o (axis_o_tdata),
    .m_tlast_o (axis_o_tlast)
  );

endmodule

// File: tb/tb_udp_checksum_check.sv
// Bench for udp_checksum_check: a large-buffer instance for the checksum
// paths and a DEPTH=16 instance for buffer overflow.
module tb_udp_checksum_check;

  typedef logic [15:0] wq_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        sresetn;
  logic        i_tready [2];
  logic        i_tvalid [2];
  logic        i_tlast  [2];
  logic [15:0] i_tdata  [2];
  logic        o_tready [2];
  logic        o_tvalid [2];
  logic        o_tlast  [2];
  logic [15:0] o_tdata  [2];
  logic        p_good   [2];
  logic        p_bad    [2];
  logic        p_ovf    [2];

  int          n_cmp = 0;
  int          n_fail = 0;
  int          rdy_mode [2];
  bit          held [2];
  logic [16:0] held_w [2];
  logic [16:0] eq0[$], eq1[$];
  int          sq0[$], sq1[$];

  udp_checksum_check #(.AXIS_BYTES(2), .DEPTH(1024)) dut (
    .clk(clk), .sresetn(sresetn),
    .axis_i_tready(i_tready[0]), .axis_i_tvalid(i_tvalid[0]),
    .axis_i_tlast(i_tlast[0]), .axis_i_tdata(i_tdata[0]),
    .axis_o_tready(o_tready[0]), .axis_o_tvalid(o_tvalid[0]),
    .axis_o_tlast(o_tlast[0]), .axis_o_tdata(o_tdata[0]),
    .pkt_good(p_good[0]), .pkt_bad_csum(p_bad[0]), .pkt_overflow(p_ovf[0])
  );

  udp_checksum_check #(.AXIS_BYTES(2), .DEPTH(16)) dut16 (
    .clk(clk), .sresetn(sresetn),
    .axis_i_tready(i_tready[1]), .axis_i_tvalid(i_tvalid[1]),
    .axis_i_tlast(i_tlast[1]), .axis_i_tdata(i_tdata[1]),
    .axis_o_tready(o_tready[1]), .axis_o_tvalid(o_tvalid[1]),
    .axis_o_tlast(o_tlast[1]), .axis_o_tdata(o_tdata[1]),
    .pkt_good(p_good[1]), .pkt_bad_csum(p_bad[1]), .pkt_overflow(p_ovf[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm, input string what);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: %s", nm, what);
  endtask

  function automatic wq_t mk(input logic [15:0] c);
    wq_t q;
    q = {16'h0A00, 16'h0001, 16'h0A00, 16'h0002, 16'h0011, 16'h000A,
         16'h1234, 16'h5678, 16'h000A, c, 16'hABCD};
    return q;
  endfunction

  // Plain integer sum, folded until it fits in 16 bits
  function automatic logic [15:0] model_fold(input wq_t w);
    int unsigned s = 0;
    foreach (w[i]) s += 32'(w[i]);
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    return 16'(s);
  endfunction

  // 1 good, 2 bad checksum, 3 overflow (DEPTH=16 instance, output stalled)
  function automatic int classify(input int d, input wq_t w);
    int pend;
    if (d == 1) begin
      pend = (eq1.size() > 0) ? eq1.size() - 1 : 0;
      if (w.size() + pend > 15) return 3;
    end
    if (model_fold(w) == 16'hFFFF) return 1;
    if (w.size() >= 10 && w[9] == 16'h0000) return 1;
    return 2;
  endfunction

  task automatic push_pkt(input int d, input wq_t w);
    int code;
    code = classify(d, w);
    if (d == 0) sq0.push_back(code);
    else        sq1.push_back(code);
    if (code == 1) begin
      foreach (w[i]) begin
        if (d == 0) eq0.push_back({i == w.size() - 1, w[i]});
        else        eq1.push_back({i == w.size() - 1, w[i]});
      end
    end
  endtask

  task automatic wait_tready(input int d, output bit ok);
    int t = 0;
    ok = 1'b1;
    while (!i_tready[d]) begin
      @(negedge clk);
      t++;
      if (t > 300) begin
        fail_now("tready_timeout", $sformatf("dut%0d input never ready", d));
        ok = 1'b0;
        break;
      end
    end
  endtask

  task automatic send(input int d, input wq_t w, input bit gap_chk);
    bit ok;
    for (int i = 0; i < w.size(); i++) begin
      @(negedge clk);
      i_tvalid[d] = 1'b1;
      i_tdata[d]  = w[i];
      i_tlast[d]  = (i == w.size() - 1);
      wait_tready(d, ok);
      if (!ok) break;
    end
    @(negedge clk);
    i_tvalid[d] = 1'b0;
    i_tlast[d]  = 1'b0;
    if (gap_chk) begin
      chk("tready_gap1", 32'(i_tready[d]), 0);
      @(negedge clk);
      chk("tready_gap2", 32'(i_tready[d]), 0);
      @(negedge clk);
      chk("tready_back", 32'(i_tready[d]), 1);
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((eq0.size() + eq1.size() + sq0.size() + sq1.size()) != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000)
      fail_now("drain_timeout", $sformatf("left beats %0d/%0d status %0d/%0d",
               eq0.size(), eq1.size(), sq0.size(), sq1.size()));
    repeat (20) @(negedge clk);
  endtask

  task automatic chk_reset_vals();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_tvalid%0d", d), 32'(o_tvalid[d]), 0);
      chk($sformatf("rst_tlast%0d", d), 32'(o_tlast[d]), 0);
      chk($sformatf("rst_tdata%0d", d), 32'(o_tdata[d]), 0);
      chk($sformatf("rst_pulses%0d", d), 32'({p_good[d], p_bad[d], p_ovf[d]}), 0);
    end
  endtask

  // Output/status checker: every negedge, for both instances
  always @(negedge clk) begin
    if (!sresetn) begin
      held[0] = 1'b0;
      held[1] = 1'b0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        logic [16:0] got, want;
        int          nst, code, want_code;
        bit          have;
        got = {o_tlast[d], o_tdata[d]};
        if (held[d]) begin
          chk($sformatf("stall_valid%0d", d), 32'(o_tvalid[d]), 1);
          chk($sformatf("stall_word%0d", d), 32'(got), 32'(held_w[d]));
        end
        case (rdy_mode[d])
          0:       o_tready[d] = 1'b0;
          1:       o_tready[d] = 1'b1;
          default: o_tready[d] = 1'($urandom_range(0, 1));
        endcase
        if (o_tvalid[d] && o_tready[d]) begin
          have = (d == 0) ? (eq0.size() > 0) : (eq1.size() > 0);
          if (!have) begin
            fail_now($sformatf("out_beat%0d", d), $sformatf("unexpected beat %h", got));
          end else begin
            want = (d == 0) ? eq0.pop_front() : eq1.pop_front();
            chk($sformatf("out_beat%0d", d), 32'(got), 32'(want));
          end
        end
        held[d]   = o_tvalid[d] && !o_tready[d];
        held_w[d] = got;
        nst = int'(p_good[d]) + int'(p_bad[d]) + int'(p_ovf[d]);
        if (nst > 1) fail_now($sformatf("status_multi%0d", d), "several status pulses at once");
        if (nst != 0) begin
          code = p_good[d] ? 1 : (p_bad[d] ? 2 : 3);
          have = (d == 0) ? (sq0.size() > 0) : (sq1.size() > 0);
          if (!have) begin
            fail_now($sformatf("status%0d", d), $sformatf("unexpected pulse code %0d", code));
          end else begin
            want_code = (d == 0) ? sq0.pop_front() : sq1.pop_front();
            chk($sformatf("status%0d", d), 32'(code), 32'(want_code));
          end
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    wq_t w, big;
    bit  ok;
    sresetn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      i_tvalid[d] = 1'b0;
      i_tlast[d]  = 1'b0;
      i_tdata[d]  = '0;
      o_tready[d] = 1'b1;
      rdy_mode[d] = 1;
    end

    // Pin the model with hand-computed sums of the reference packet
    chk("model_sum_ok", 32'(model_fold(mk(16'hD75D))), 32'h0000_FFFF);
    chk("model_sum_bad", 32'(model_fold(mk(16'hD75C))), 32'h0000_FFFE);
    chk("model_sum_zero", 32'(model_fold(mk(16'h0000))), 32'h0000_28A2);
    chk("model_class_zero", 32'(classify(0, mk(16'h0000))), 1);

    repeat (3) @(negedge clk);
    chk_reset_vals();
    sresetn = 1'b1;
    @(negedge clk);
    chk("tready_after_rst0", 32'(i_tready[0]), 1);
    chk("tready_after_rst1", 32'(i_tready[1]), 1);

    // Valid checksum, bad checksum then good, zero checksum
    push_pkt(0, mk(16'hD75D)); send(0, mk(16'hD75D), 1);
    wait_drain();
    push_pkt(0, mk(16'hD75C)); send(0, mk(16'hD75C), 1);
    push_pkt(0, mk(16'hD75D)); send(0, mk(16'hD75D), 1);
    wait_drain();
    push_pkt(0, mk(16'h0000)); send(0, mk(16'h0000), 1);
    wait_drain();

    // Short packets: no checksum field, so only a 0xFFFF sum passes
    w = {16'h1234, 16'hEDCB};
    push_pkt(0, w); send(0, w, 1);
    w = mk(16'h0000); void'(w.pop_back()); void'(w.pop_back());
    push_pkt(0, w); send(0, w, 1);
    w = mk(16'h0000); void'(w.pop_back());
    push_pkt(0, w); send(0, w, 1);
    wait_drain();

    // Overflow on the 16-deep instance with a committed packet waiting
    rdy_mode[1] = 0;
    push_pkt(1, mk(16'hD75D)); send(1, mk(16'hD75D), 1);
    repeat (5) @(negedge clk);
    big = {};
    for (int i = 0; i < 20; i++) big.push_back(16'(16'h1111 * (i + 1)));
    push_pkt(1, big); send(1, big, 0);
    repeat (10) @(negedge clk);
    rdy_mode[1] = 1;
    wait_drain();

    // Back-to-back packets with a random output consumer
    rdy_mode[0] = 2;
    push_pkt(0, mk(16'hD75D)); send(0, mk(16'hD75D), 1);
    push_pkt(0, mk(16'h0000)); send(0, mk(16'h0000), 1);
    push_pkt(0, mk(16'hD75D)); send(0, mk(16'hD75D), 1);
    wait_drain();

    // Reset during word 5 while the previous packet is still draining
    push_pkt(0, mk(16'hD75D)); send(0, mk(16'hD75D), 1);
    w = mk(16'hD75D);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      i_tvalid[0] = 1'b1;
      i_tdata[0]  = w[i];
      i_tlast[0]  = 1'b0;
      wait_tready(0, ok);
    end
    @(negedge clk);
    i_tdata[0] = w[5];
    sresetn    = 1'b0;
    @(negedge clk);
    chk_reset_vals();
    eq0.delete(); eq1.delete(); sq0.delete(); sq1.delete();
    @(negedge clk);
    chk_reset_vals();
    i_tvalid[0] = 1'b0;
    sresetn     = 1'b1;
    @(negedge clk);
    chk("tready_after_rst2", 32'(i_tready[0]), 1);
    chk("tvalid_after_rst2", 32'(o_tvalid[0]), 0);
    push_pkt(0, mk(16'hD75D)); send(0, mk(16'hD75D), 1);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/udp_checksum_check.md
UDP_CHECKSUM_CHECK -- requirements
Module: udp_checksum_check

Interface
REQ-001 Parameter AXIS_BYTES, default 2, data bytes per beat; SHALL be 2 or 4 (static assertion).
REQ-002 Parameter DEPTH, default 1024, packet buffer words; SHALL be a power of two, at least 16.
REQ-003 clk  input  1  clock.
REQ-004 sresetn  input  1  reset; synchronous, active-low.
REQ-005 axis_i_tready/tvalid/tlast  out/in/in  1 each  input stream handshake and last.
REQ-006 axis_i_tdata  input  AXIS_BYTES*8  IPv4 pseudo-header, UDP header, payload (zero-padded); first byte in MSBs.
REQ-007 axis_o_tready/tvalid/tlast  in/out/out  1 each  output stream handshake and last.
REQ-008 axis_o_tdata  output  AXIS_BYTES*8  accepted packets, unchanged and pseudo-header included.
REQ-009 pkt_good, pkt_bad_csum, pkt_overflow  output  1 each  one-cycle status pulses, one per input packet.

Function
REQ-010 Store-and-forward: every input beat written to a circular buffer of DEPTH x (AXIS_BYTES*8+1) bits (data plus tlast).
REQ-011 Running sum: per-16-bit-lane 17-bit one's-complement accumulators, end-around carry added each beat; for AXIS_BYTES=4, lanes folded after tlast.
REQ-012 Checksum field is packet bytes 18-19: word 9 (AXIS_BYTES=2) or word 4 bits [15:0] (AXIS_BYTES=4); captured while receiving.
REQ-013 Packet good when folded sum == 0xFFFF or captured checksum field == 0x0000.
REQ-014 States: RECV (accept beats), FOLD (1 cycle for AXIS_BYTES=2, 2 cycles for 4; tready low), DECIDE (1 cycle), DROP (drain after overflow).
REQ-015 RECV->FOLD on tlast handshake; FOLD->DECIDE; DECIDE->RECV.
REQ-016 DECIDE good: commit pointer <= write pointer, pulse pkt_good; bad: write pointer <= commit pointer, pulse pkt_bad_csum.
REQ-017 Beat arriving with buffer full (write pointer + 1 == read pointer): write pointer rewound to commit pointer; enter DROP (or pulse pkt_overflow immediately if that beat has tlast).
REQ-018 DROP: tready high, beats discarded; on tlast pulse pkt_overflow, clear accumulators, return to RECV.
REQ-019 axis_i_tready high only in RECV and DROP.
REQ-020 Accumulators and checksum capture cleared in DECIDE and on leaving DROP.
REQ-021 Output reads only committed words (read pointer != commit pointer); registered read, tvalid held until tready, tdata/tlast stable while stalled.
REQ-022 First output beat of a packet committed in cycle D SHALL be valid by cycle D+2 when output idle and tready high; then 1 beat/cycle throughput.
REQ-023 Output reads and input writes proceed concurrently; a commit in the same cycle as an output read SHALL lose no beat.
REQ-024 Packet shorter than 10 words (AXIS_BYTES=2) or 5 words (AXIS_BYTES=4): checksum field treated as absent; good only if folded sum == 0xFFFF.

Reset
REQ-025 On sresetn low: all pointers 0, state RECV, accumulators 0, axis_o_tvalid 0, axis_o_tlast 0, axis_o_tdata 0, all status pulses 0, axis_i_tready 1 from the first cycle after release.
REQ-026 Reset mid-packet or mid-output SHALL discard all buffered data, including committed packets.

Structure
REQ-027 A shared network package SHALL hold the UDP checksum byte offset (18) and the one's-complement add-with-carry function (also usable by udp_checksum).
REQ-028 A single sub-module axis_packet_fifo (buffer, write/commit/read pointers, commit/rewind inputs) SHALL be instantiated; checksum logic and FSM stay in the top.

Verification (AXIS_BYTES=2; words: 0A00 0001 0A00 0002 0011 000A 1234 5678 000A C ABCD)
REQ-029 C=D75D -> pkt_good once; 11 identical words out, tlast on word 11.
REQ-030 C=D75C -> pkt_bad_csum once; no output beats; next good packet passes intact.
REQ-031 C=0000 -> pkt_good; packet forwarded unchanged.
REQ-032 DEPTH=16, 20-word packet -> pkt_overflow after tlast; no output; committed earlier packet still output intact.
REQ-033 Three good packets back-to-back with random axis_o_tready -> 33 beats out in order, no loss or duplication; tready low exactly 2 cycles after each tlast.
REQ-034 sresetn low during word 5 of a packet and while a prior packet is draining -> outputs at reset values; next packet processed as good.
